// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: captures the MEM-stage slot, selects write-back data
// and counts retired instructions. Flush loads a bubble and overrides stall.
module mem_wb_register #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic                      in_reg_write,
    input  logic                      in_mem_to_reg,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0]     in_alu_result,
    input  logic [DATA_WIDTH-1:0]     in_read_data,
    output logic                      out_valid,
    output logic                      out_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0]     out_write_data,
    output logic                      fwd_valid,
    output logic [63:0]               retired_count
);

    logic                      valid_q;
    logic                      reg_write_q;
    logic                      mem_to_reg_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]     alu_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [63:0]               retired_q;

    logic capture;
    logic retire;

    assign capture = !flush && !stall;
    assign retire  = capture && in_valid;

    // Data fields are captured even for invalid slots; out_valid gates their use.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= '0;
            alu_q        <= '0;
            rdata_q      <= '0;
        end else if (flush) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= '0;
            alu_q        <= '0;
            rdata_q      <= '0;
        end else if (capture) begin
            valid_q      <= in_valid;
            reg_write_q  <= in_reg_write;
            mem_to_reg_q <= in_mem_to_reg;
            rd_q         <= in_rd;
            alu_q        <= in_alu_result;
            rdata_q      <= in_read_data;
        end
    end

    // Wraps silently at 2^64.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 64'd1;
        end
    end

    assign out_valid      = valid_q;
    assign out_rd         = rd_q;
    assign out_write_data = mem_to_reg_q ? rdata_q : alu_q;
    assign out_reg_write  = reg_write_q && valid_q && (rd_q != '0);
    assign fwd_valid      = out_reg_write;
    assign retired_count  = retired_q;

endmodule
